// File: rtl/vector_alu_sequencer_pkg.sv
// rtl/vector_alu_sequencer_pkg.sv - shared vector ALU op codes, FSM states and element width
package rv32v_pkg;

    localparam int ELEN_DEF = 32;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Every code with the top bit set is reserved.
    function automatic logic is_legal_op(input logic [3:0] op);
        return ~op[3];
    endfunction

endpackage

// File: rtl/vector_alu_sequencer_if.sv
// rtl/vector_alu_sequencer_if.sv - issue and write-back handshake bundle of the vector sequencer
interface vector_alu_sequencer_if #(
    parameter int ELEN     = rv32v_pkg::ELEN_DEF,
    parameter int NUM_ELEM = 8
);
    logic                     start_valid;
    logic                     start_ready;
    logic [3:0]               alu_control;
    logic                     reg_write_V;
    logic [4:0]               vd_addr;
    logic [NUM_ELEM*ELEN-1:0] vs1_data;
    logic [NUM_ELEM*ELEN-1:0] vs2_data;
    logic                     result_valid;
    logic                     result_ready;
    logic [NUM_ELEM*ELEN-1:0] result_data;
    logic [4:0]               result_vd_addr;
    logic                     result_we;
    logic                     illegal_op;
    logic                     busy;

    modport master (
        output start_valid, alu_control, reg_write_V, vd_addr, vs1_data, vs2_data, result_ready,
        input  start_ready, result_valid, result_data, result_vd_addr, result_we, illegal_op, busy
    );

    modport slave (
        input  start_valid, alu_control, reg_write_V, vd_addr, vs1_data, vs2_data, result_ready,
        output start_ready, result_valid, result_data, result_vd_addr, result_we, illegal_op, busy
    );

endinterface

// File: rtl/vector_alu_sequencer_lane_alu.sv
// rtl/vector_alu_sequencer_lane_alu.sv - combinational single-element ALU used once per lane
module vector_lane_alu
    import rv32v_pkg::*;
#(
    parameter int ELEN = ELEN_DEF
) (
    input  logic [3:0]      op_i,
    input  logic [ELEN-1:0] a_i,
    input  logic [ELEN-1:0] b_i,
    output logic [ELEN-1:0] y_o,
    output logic            illegal_o
);

    logic [4:0] shamt;

    assign shamt     = b_i[4:0];
    assign illegal_o = ~is_legal_op(op_i);

    always_comb begin
        y_o = '0;
        case (op_i)
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_SLT: y_o = ELEN'($signed(a_i) < $signed(b_i));
            ALU_SLL: y_o = a_i << shamt;
            ALU_SRL: y_o = a_i >> shamt;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/vector_alu_sequencer.sv
// rtl/vector_alu_sequencer.sv - multi-cycle vector execute stage, LANES elements per cycle
module vector_alu_sequencer
    import rv32v_pkg::*;
#(
    parameter int ELEN     = ELEN_DEF,
    parameter int NUM_ELEM = 8,
    parameter int LANES    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    vector_alu_sequencer_if.slave  bus
);

    localparam int VW = NUM_ELEM * ELEN;
    localparam int IW = $clog2(NUM_ELEM + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d, sel_idx;
    logic [3:0]      op_q, op_d;
    logic            we_q, we_d;
    logic            ill_q, ill_d;
    logic [4:0]      vd_q, vd_d;
    logic [VW-1:0]   vs1_q, vs1_d;
    logic [VW-1:0]   vs2_q, vs2_d;
    logic [VW-1:0]   res_q, res_d;

    logic            accept;
    logic            compute;
    logic [ELEN-1:0] lane_a [LANES];
    logic [ELEN-1:0] lane_b [LANES];
    logic [ELEN-1:0] lane_y [LANES];
    logic [LANES-1:0] lane_ill;

    assign accept  = (state_q == ST_IDLE) && bus.start_valid;
    // Once idx reaches NUM_ELEM the EXEC cycle only hands over to DONE.
    assign compute = (state_q == ST_EXEC) && (idx_q != IW'(NUM_ELEM));
    assign sel_idx = compute ? idx_q : '0;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_a[g] = vs1_q[(int'(sel_idx) + g) * ELEN +: ELEN];
        assign lane_b[g] = vs2_q[(int'(sel_idx) + g) * ELEN +: ELEN];

        vector_lane_alu #(.ELEN(ELEN)) u_lane_alu (
            .op_i      (op_q),
            .a_i       (lane_a[g]),
            .b_i       (lane_b[g]),
            .y_o       (lane_y[g]),
            .illegal_o (lane_ill[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: if (idx_q == IW'(NUM_ELEM)) state_d = ST_DONE;
            ST_DONE: if (bus.result_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.start_ready  = (state_q == ST_IDLE);
        bus.busy         = (state_q != ST_IDLE);
        bus.result_valid = (state_q == ST_DONE);
        bus.result_we    = (state_q == ST_DONE) && we_q && !ill_q;
        bus.illegal_op   = (state_q == ST_DONE) && ill_q;
    end

    assign bus.result_data    = res_q;
    assign bus.result_vd_addr = vd_q;

    always_comb begin
        idx_d = idx_q;
        op_d  = op_q;
        we_d  = we_q;
        ill_d = ill_q;
        vd_d  = vd_q;
        vs1_d = vs1_q;
        vs2_d = vs2_q;
        res_d = res_q;
        if (accept) begin
            idx_d = '0;
            op_d  = bus.alu_control;
            we_d  = bus.reg_write_V;
            ill_d = 1'b0;
            vd_d  = bus.vd_addr;
            vs1_d = bus.vs1_data;
            vs2_d = bus.vs2_data;
        end else if (compute) begin
            for (int k = 0; k < LANES; k++) begin
                res_d[(int'(idx_q) + k) * ELEN +: ELEN] = lane_y[k];
            end
            ill_d = ill_q | (|lane_ill);
            idx_d = idx_q + IW'(LANES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            op_q  <= '0;
            we_q  <= 1'b0;
            ill_q <= 1'b0;
            vd_q  <= '0;
            vs1_q <= '0;
            vs2_q <= '0;
            res_q <= '0;
        end else begin
            idx_q <= idx_d;
            op_q  <= op_d;
            we_q  <= we_d;
            ill_q <= ill_d;
            vd_q  <= vd_d;
            vs1_q <= vs1_d;
            vs2_q <= vs2_d;
            res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// tb/tb_vector_alu_sequencer.sv - scoreboard bench for the vector execute sequencer
module tb_vector_alu_sequencer;
    import rv32v_pkg::*;

    localparam int ELEN = 32;
    localparam int NE   = 8;
    localparam int L    = 2;
    localparam int VW   = NE * ELEN;

    typedef struct {
        logic [VW-1:0] data;
        logic [4:0]    vd;
        logic          we;
        logic          ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    vector_alu_sequencer_if #(.ELEN(ELEN), .NUM_ELEM(NE)) bus ();

    vector_alu_sequencer #(.ELEN(ELEN), .NUM_ELEM(NE), .LANES(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_elem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return a ^ b;
            4'b0010: return a + b;
            4'b0011: return a + ~b + 32'd1;
            4'b0100: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0101: return a << sh;
            4'b0110: return a >> sh;
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue(input logic [3:0] op, input logic we, input logic [4:0] vd,
                         input logic [VW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        @(negedge clk);
        chk("start_ready_before_issue", bus.start_ready, 1);
        for (int i = 0; i < NE; i++) e.data[i*ELEN +: ELEN] = ref_elem(op, a[i*ELEN +: ELEN], b[i*ELEN +: ELEN]);
        e.vd  = vd;
        e.ill = op[3];
        e.we  = we & ~op[3];
        sb.push_back(e);
        bus.alu_control = op;
        bus.reg_write_V = we;
        bus.vd_addr     = vd;
        bus.vs1_data    = a;
        bus.vs2_data    = b;
        bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int stall);
        int   lat = 0;
        exp_t e;
        logic [VW-1:0] held;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.result_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_latency"}, lat, 5);
        if (sb.size() == 0) begin
            chk({tag, "_scoreboard_nonempty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_data"}, bus.result_data, e.data);
        chk({tag, "_vd"}, bus.result_vd_addr, e.vd);
        chk({tag, "_we"}, bus.result_we, e.we);
        chk({tag, "_illegal"}, bus.illegal_op, e.ill);
        held = bus.result_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            bus.start_valid = (s == 1);
            bus.alu_control = 4'b0010;
            @(posedge clk);
            #1;
            chk({tag, "_stall_valid"}, bus.result_valid, 1);
            chk({tag, "_stall_data"}, bus.result_data, held);
            chk({tag, "_stall_vd"}, bus.result_vd_addr, e.vd);
            chk({tag, "_stall_we"}, bus.result_we, e.we);
            chk({tag, "_stall_start_ready"}, bus.start_ready, 0);
        end
        @(negedge clk);
        bus.start_valid  = 1'b0;
        bus.result_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_hs_valid_drop"}, bus.result_valid, 0);
        chk({tag, "_hs_idle"}, bus.start_ready, 1);
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    initial begin
        logic [VW-1:0] a, b;

        rst_n            = 1'b0;
        bus.start_valid  = 1'b0;
        bus.alu_control  = '0;
        bus.reg_write_V  = 1'b0;
        bus.vd_addr      = '0;
        bus.vs1_data     = '0;
        bus.vs2_data     = '0;
        bus.result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_ready", bus.start_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.result_valid, 0);
        chk("rst_data", bus.result_data, 0);
        chk("rst_vd", bus.result_vd_addr, 0);
        chk("rst_we", bus.result_we, 0);
        chk("rst_illegal", bus.illegal_op, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = i; b[i*ELEN +: ELEN] = 32'h10; end
        issue(4'b0010, 1'b1, 5'd3, a, b);
        collect("add", 0);

        for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = 32'h0; b[i*ELEN +: ELEN] = 32'h1; end
        issue(4'b0011, 1'b1, 5'd4, a, b);
        collect("sub", 0);

        for (int i = 0; i < NE; i++) begin
            a[i*ELEN +: ELEN] = i[0] ? 32'h1 : 32'hFFFF_FFFF;
            b[i*ELEN +: ELEN] = i[0] ? 32'hFFFF_FFFF : 32'h1;
        end
        issue(4'b0100, 1'b1, 5'd5, a, b);
        collect("slt", 0);

        for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = 32'h1; b[i*ELEN +: ELEN] = 32'd33; end
        issue(4'b0101, 1'b1, 5'd6, a, b);
        collect("sll", 0);

        for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = 32'h8000_0000; b[i*ELEN +: ELEN] = 32'd31; end
        issue(4'b0110, 1'b0, 5'd7, a, b);
        collect("srl", 0);

        for (int op = 0; op < 3; op++) begin
            logic [3:0] opc;
            opc = (op == 0) ? 4'b0000 : (op == 1) ? 4'b0001 : 4'b0111;
            for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = $urandom; b[i*ELEN +: ELEN] = $urandom; end
            issue(opc, 1'b1, 5'(op + 10), a, b);
            collect("logic", 0);
        end

        for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = $urandom; b[i*ELEN +: ELEN] = $urandom; end
        issue(4'b0111, 1'b1, 5'd21, a, b);
        collect("backpressure", 3);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_pulse_ignored_busy", bus.busy, 0);
            chk("bp_pulse_ignored_valid", bus.result_valid, 0);
        end

        for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = $urandom; b[i*ELEN +: ELEN] = 32'd5; end
        issue(4'b0010, 1'b1, 5'd9, a, b);
        @(posedge clk);
        #1;
        chk("midexec_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midexec_rst_start_ready", bus.start_ready, 1);
        chk("midexec_rst_busy", bus.busy, 0);
        chk("midexec_rst_valid", bus.result_valid, 0);
        chk("midexec_rst_data", bus.result_data, 0);
        chk("midexec_rst_vd", bus.result_vd_addr, 0);
        chk("midexec_rst_we", bus.result_we, 0);
        chk("midexec_rst_illegal", bus.illegal_op, 0);
        void'(sb.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = 32'hFFFF_FFF0 + i; b[i*ELEN +: ELEN] = 32'h20; end
        issue(4'b0010, 1'b1, 5'd30, a, b);
        collect("add_after_reset", 0);

        for (int i = 0; i < NE; i++) begin a[i*ELEN +: ELEN] = $urandom | 32'h1; b[i*ELEN +: ELEN] = $urandom | 32'h1; end
        issue(4'b1010, 1'b1, 5'd17, a, b);
        collect("illegal", 0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
